key_event_ctrl: RTL and testbench

- Consumes the debounced, active-low key levels from the key-filter stage, one FSM per key.
- Classifies each key's activity into CLICK, DOUBLE, LONG and REPEAT events.
- A round-robin arbiter shares a single valid/ready event port between all keys, feeding the UI/LED control logic.
- Per-key single-entry pending slots, with a sticky overflow flag per key.

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_evt_fsm.sv | 95 +++++++++
 rtl/key_event_ctrl.sv | 113 +++++++++++
 tb/tb_key_event_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types for the key event controller: FSM states, event codes, pending slot.
package key_pkg;

  localparam int unsigned EVT_CODE_W = 2;

  typedef enum logic [2:0] {
    KS_IDLE  = 3'd0,
    KS_DOWN1 = 3'd1,
    KS_HOLD  = 3'd2,
    KS_GAP   = 3'd3,
    KS_DOWN2 = 3'd4
  } key_state_e;

  typedef enum logic [EVT_CODE_W-1:0] {
    EVT_CLICK  = 2'd0,
    EVT_DOUBLE = 2'd1,
    EVT_LONG   = 2'd2,
    EVT_REPEAT = 2'd3
  } evt_code_e;

  typedef struct packed {
    logic      v;
    evt_code_e code;
  } pend_slot_t;

endpackage

// File: rtl/key_evt_fsm.sv
// Single-key classifier: edge detect on the debounced level, then CLICK/DOUBLE/LONG/REPEAT.
module key_evt_fsm
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned DCLICK_CYC = 15_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      key_lvl,
  output logic      emit_c,
  output evt_code_e code_c
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_d;
  logic             press_c, release_c;

  // Level is active-low: a press is a 1->0 transition.
  assign press_c   = key_d & ~key_lvl;
  assign release_c = ~key_d & key_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= KS_IDLE;
      cnt   <= '0;
      key_d <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      key_d <= key_lvl;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (state == KS_IDLE) ? '0 : cnt + CNT_W'(1);
    emit_c    = 1'b0;
    code_c    = EVT_CLICK;
    case (state)
      KS_IDLE: begin
        if (press_c) state_nxt = KS_DOWN1;
      end
      KS_DOWN1: begin
        if (release_c) begin
          state_nxt = KS_GAP;
        end else if (cnt == LONG_LAST) begin
          emit_c    = 1'b1;
          code_c    = EVT_LONG;
          state_nxt = KS_HOLD;
        end
      end
      KS_HOLD: begin
        if (release_c) begin
          state_nxt = KS_IDLE;
        end else if (cnt == REPEAT_LAST) begin
          emit_c  = 1'b1;
          code_c  = EVT_REPEAT;
          cnt_nxt = '0;
        end
      end
      KS_GAP: begin
        if (press_c) begin
          state_nxt = KS_DOWN2;
        end else if (cnt == DCLICK_LAST) begin
          emit_c    = 1'b1;
          code_c    = EVT_CLICK;
          state_nxt = KS_IDLE;
        end
      end
      KS_DOWN2: begin
        // A second press held to LONG drops the pending first click.
        if (release_c) begin
          emit_c    = 1'b1;
          code_c    = EVT_DOUBLE;
          state_nxt = KS_IDLE;
        end else if (cnt == LONG_LAST) begin
          emit_c    = 1'b1;
          code_c    = EVT_LONG;
          state_nxt = KS_HOLD;
        end
      end
      default: state_nxt = KS_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Per-key event classifiers feeding single-entry pending slots, drained round-robin to one valid/ready port.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned KEY_W      = 3,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned DCLICK_CYC = 15_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_W-1:0]      key_lvl,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IDX_W-1:0]      evt_key,
  output logic [EVT_CODE_W-1:0] evt_code,
  output logic [KEY_W-1:0]      ovf,
  input  logic                  ovf_clr
);

  logic [KEY_W-1:0] emit_c;
  evt_code_e        code_c [KEY_W];
  pend_slot_t       pend   [KEY_W];
  logic [KEY_W-1:0] pend_v_c;
  logic [KEY_W-1:0] take_c;
  logic [KEY_W-1:0] ovf_set_c;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx_c;
  logic [IDX_W-1:0] rr_nxt_c;
  logic [IDX_W:0]   cand_c;
  logic             gnt_v_c;
  logic             load_c;

  for (genvar g = 0; g < KEY_W; g++) begin : g_key
    key_evt_fsm #(
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .DCLICK_CYC (DCLICK_CYC),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_lvl (key_lvl[g]),
      .emit_c  (emit_c[g]),
      .code_c  (code_c[g])
    );
  end

  assign load_c = !evt_valid || evt_ready;

  // Round-robin search starting at rr_ptr, wrapping at KEY_W-1.
  always_comb begin
    gnt_v_c   = 1'b0;
    gnt_idx_c = '0;
    cand_c    = '0;
    for (int unsigned k = 0; k < KEY_W; k++) begin
      cand_c = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand_c >= (IDX_W+1)'(KEY_W)) cand_c = cand_c - (IDX_W+1)'(KEY_W);
      if (!gnt_v_c && pend[cand_c[IDX_W-1:0]].v) begin
        gnt_v_c   = 1'b1;
        gnt_idx_c = cand_c[IDX_W-1:0];
      end
    end
    rr_nxt_c = (gnt_idx_c == IDX_W'(KEY_W - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
  end

  always_comb begin
    take_c   = '0;
    pend_v_c = '0;
    for (int unsigned i = 0; i < KEY_W; i++) pend_v_c[i] = pend[i].v;
    if (load_c && gnt_v_c) take_c[gnt_idx_c] = 1'b1;
    ovf_set_c = emit_c & pend_v_c & ~take_c;
  end

  // A new event always lands in its slot; overflow only if the old one was not drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < KEY_W; i++) pend[i] <= '0;
      ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < KEY_W; i++) begin
        if (emit_c[i]) begin
          pend[i].v    <= 1'b1;
          pend[i].code <= code_c[i];
        end else if (take_c[i]) begin
          pend[i].v <= 1'b0;
        end
      end
      ovf <= (ovf & ~{KEY_W{ovf_clr}}) | ovf_set_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_code  <= '0;
      rr_ptr    <= '0;
    end else if (load_c) begin
      if (gnt_v_c) begin
        evt_valid <= 1'b1;
        evt_key   <= gnt_idx_c;
        evt_code  <= EVT_CODE_W'(pend[gnt_idx_c].code);
        rr_ptr    <= rr_nxt_c;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with shortened timing constants.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_key;
  logic [1:0] evt_code;
  logic [2:0] ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int key;
    int code;
    int stamp;
  } hs_t;
  hs_t hs_q[$];

  key_event_ctrl #(
    .KEY_W      (3),
    .IDX_W      (2),
    .LONG_CYC   (20),
    .REPEAT_CYC (8),
    .DCLICK_CYC (10),
    .CNT_W      (26)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_lvl   (key_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_code  (evt_code),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      hs_q.push_back('{key: int'(evt_key), code: int'(evt_code), stamp: cyc});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_lvl   = 3'b111;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    step(3);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_key",   32'(evt_key),   0);
    check("rst_code",  32'(evt_code),  0);
    check("rst_ovf",   32'(ovf),       0);
    rst_n = 1'b1;
    step(2);
    check("post_rst_valid", 32'(evt_valid), 0);

    // Short click on key0: release cycle R, valid after the 12th edge.
    hs_q.delete();
    key_lvl = 3'b110; step(5);
    key_lvl = 3'b111;
    step(11);
    check("click_early", 32'(evt_valid), 0);
    step(1);
    check("click_valid", 32'(evt_valid), 1);
    check("click_key",   32'(evt_key),   0);
    check("click_code",  32'(evt_code),  0);
    step(1);
    check("click_drop",  32'(evt_valid), 0);
    step(5);
    check("click_count", 32'(hs_q.size()), 1);

    // Double click on key1.
    hs_q.delete();
    key_lvl = 3'b101; step(5);
    key_lvl = 3'b111; step(4);
    key_lvl = 3'b101; step(5);
    key_lvl = 3'b111;
    step(1);
    check("dbl_early", 32'(evt_valid), 0);
    step(1);
    check("dbl_valid", 32'(evt_valid), 1);
    check("dbl_key",   32'(evt_key),   1);
    check("dbl_code",  32'(evt_code),  1);
    step(15);
    check("dbl_count", 32'(hs_q.size()), 1);

    // Long press on key2 held 40 cycles: LONG then two REPEATs.
    hs_q.delete();
    key_lvl = 3'b011;
    step(21);
    check("long_early", 32'(evt_valid), 0);
    step(1);
    check("long_valid", 32'(evt_valid), 1);
    check("long_key",   32'(evt_key),   2);
    check("long_code",  32'(evt_code),  2);
    step(18);
    key_lvl = 3'b111;
    step(20);
    check("long_count", 32'(hs_q.size()), 3);
    check("rep1_code",  32'(hs_q[1].code), 3);
    check("rep2_code",  32'(hs_q[2].code), 3);
    check("rep2_key",   32'(hs_q[2].key),  2);
    check("rep1_gap",   32'(hs_q[1].stamp - hs_q[0].stamp), 8);
    check("rep2_gap",   32'(hs_q[2].stamp - hs_q[1].stamp), 8);

    // Three simultaneous CLICKs drained in rr order 0,1,2.
    hs_q.delete();
    key_lvl = 3'b000; step(3);
    key_lvl = 3'b111;
    step(11);
    check("arb_early", 32'(evt_valid), 0);
    step(1);
    check("arb_key0", 32'(evt_key), 0);
    check("arb_v0",   32'(evt_valid), 1);
    step(1);
    check("arb_key1", 32'(evt_key), 1);
    step(1);
    check("arb_key2", 32'(evt_key), 2);
    check("arb_code2", 32'(evt_code), 0);
    step(1);
    check("arb_drop", 32'(evt_valid), 0);
    check("arb_count", 32'(hs_q.size()), 3);

    // Backpressure: CLICK stuck in output, CLICK pending, LONG overwrites it.
    evt_ready = 1'b0;
    hs_q.delete();
    key_lvl = 3'b110; step(3);
    key_lvl = 3'b111; step(12);
    check("bp_valid", 32'(evt_valid), 1);
    check("bp_code",  32'(evt_code),  0);
    step(2);
    check("bp_hold_code", 32'(evt_code), 0);
    key_lvl = 3'b110; step(3);
    key_lvl = 3'b111; step(11);
    check("bp_no_ovf", 32'(ovf), 0);
    key_lvl = 3'b110;
    step(20);
    check("bp_ovf_before", 32'(ovf), 0);
    step(1);
    check("bp_ovf_set", 32'(ovf), 1);
    key_lvl = 3'b111;
    check("bp_stable_key",  32'(evt_key),   0);
    check("bp_stable_code", 32'(evt_code),  0);
    check("bp_stable_v",    32'(evt_valid), 1);
    ovf_clr = 1'b1; step(1);
    ovf_clr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 0);
    evt_ready = 1'b1;
    step(1);
    check("bp_drain_valid", 32'(evt_valid), 1);
    check("bp_drain_code",  32'(evt_code),  2);
    step(1);
    check("bp_empty",  32'(evt_valid), 0);
    check("bp_count",  32'(hs_q.size()), 2);
    check("bp_first",  32'(hs_q[0].code), 0);
    check("bp_second", 32'(hs_q[1].code), 2);

    // Async reset in HOLD with a stuck event and overflow.
    evt_ready = 1'b0;
    hs_q.delete();
    key_lvl = 3'b011;
    step(38);
    check("ar_valid", 32'(evt_valid), 1);
    check("ar_key",   32'(evt_key),   2);
    check("ar_ovf",   32'(ovf),       3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rst_valid", 32'(evt_valid), 0);
    check("ar_rst_key",   32'(evt_key),   0);
    check("ar_rst_code",  32'(evt_code),  0);
    check("ar_rst_ovf",   32'(ovf),       0);
    key_lvl = 3'b111;
    step(2);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    step(30);
    check("ar_quiet_valid", 32'(evt_valid), 0);
    check("ar_quiet_count", 32'(hs_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
